// File: rtl/snj_loader_pkg.sv
// Shared types and constants for the SNJ ROM loader.
// Region map, FSM encoding and the default ROM size.
package snj_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam logic [3:0] REG_CPU  = 4'b0001;
    localparam logic [3:0] REG_CHR  = 4'b0010;
    localparam logic [3:0] REG_SPR  = 4'b0100;
    localparam logic [3:0] REG_PROM = 4'b1000;

    localparam logic [15:0] BASE_CHR  = 16'h6000;
    localparam logic [15:0] BASE_SPR  = 16'h8000;
    localparam logic [15:0] BASE_PROM = 16'hA000;

    localparam logic [15:0] ROM_SIZE_DEF = 16'hA060;

endpackage

// File: rtl/snj_region_decode.sv
// Combinational byte address -> {in_range, one-hot region} decode.
// The full 25-bit address takes part in the range test.
module snj_region_decode
    import snj_loader_pkg::*;
#(
    parameter logic [15:0] ROM_SIZE = ROM_SIZE_DEF
) (
    input  logic [24:0] addr,
    output logic        in_range,
    output logic [3:0]  region
);

    always_comb begin
        in_range = (addr < {9'd0, ROM_SIZE});
        region   = 4'b0000;
        if (in_range) begin
            if (addr[15:0] < BASE_CHR)
                region = REG_CPU;
            else if (addr[15:0] < BASE_SPR)
                region = REG_CHR;
            else if (addr[15:0] < BASE_PROM)
                region = REG_SPR;
            else
                region = REG_PROM;
        end
    end

endmodule

// File: rtl/snj_rom_loader.sv
// HPS ioctl download -> core ROM write port, with core reset sequencing.
// Define SNJ_LOADER_CHECKSUM_EN to gate the release on a byte checksum.
module snj_rom_loader
    import snj_loader_pkg::*;
#(
    parameter int          RELEASE_CYCLES = 16,
    parameter logic [15:0] ROM_SIZE       = ROM_SIZE_DEF
`ifdef SNJ_LOADER_CHECKSUM_EN
    ,
    parameter logic [15:0] EXPECTED_CSUM  = 16'h0000
`endif
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        dn_wr,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic [3:0]  dn_region,
    output logic        core_reset,
    output logic        rom_ready,
    output logic        overflow
`ifdef SNJ_LOADER_CHECKSUM_EN
    ,
    output logic [15:0] csum,
    output logic        csum_ok
`endif
);

    logic [1:0]  rst_sync;
    logic        rst_n;
    state_t      state;
    logic [15:0] cnt;
    logic        in_range;
    logic [3:0]  region;
    logic        wr_live;
    logic        accept;
    logic        reject;
    logic        enter_load;
    logic        csum_pass;

    // Assert immediately, release two clocks after reset_n rises.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    snj_region_decode #(
        .ROM_SIZE (ROM_SIZE)
    ) u_decode (
        .addr     (ioctl_addr),
        .in_range (in_range),
        .region   (region)
    );

    assign wr_live    = (state == ST_LOAD) && ioctl_download && ioctl_wr;
    assign accept     = wr_live && in_range;
    assign reject     = wr_live && !in_range;
    assign enter_load = ioctl_download && (state != ST_LOAD);

`ifdef SNJ_LOADER_CHECKSUM_EN
    assign csum_pass = csum_ok;
`else
    assign csum_pass = 1'b1;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= 16'd0;
            core_reset <= 1'b1;
            rom_ready  <= 1'b0;
            dn_wr      <= 1'b0;
            dn_addr    <= 16'd0;
            dn_data    <= 8'd0;
            dn_region  <= 4'd0;
            overflow   <= 1'b0;
`ifdef SNJ_LOADER_CHECKSUM_EN
            csum       <= 16'd0;
            csum_ok    <= 1'b0;
`endif
        end else begin
            dn_wr      <= 1'b0;
            dn_region  <= 4'd0;
            core_reset <= 1'b1;
            rom_ready  <= 1'b0;

            if (accept) begin
                dn_wr     <= 1'b1;
                dn_addr   <= ioctl_addr[15:0];
                dn_data   <= ioctl_dout;
                dn_region <= region;
`ifdef SNJ_LOADER_CHECKSUM_EN
                csum      <= csum + {8'd0, ioctl_dout};
`endif
            end

            if (enter_load) begin
                overflow <= 1'b0;
`ifdef SNJ_LOADER_CHECKSUM_EN
                csum     <= 16'd0;
                csum_ok  <= 1'b0;
`endif
            end else if (reject) begin
                overflow <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (ioctl_download)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (!ioctl_download) begin
                        state <= ST_RELEASE;
                        cnt   <= 16'(RELEASE_CYCLES - 1);
`ifdef SNJ_LOADER_CHECKSUM_EN
                        csum_ok <= (csum == EXPECTED_CSUM);
`endif
                    end
                end
                ST_RELEASE: begin
                    if (ioctl_download) begin
                        state <= ST_LOAD;
                    end else if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (csum_pass) begin
                        state      <= ST_RUN;
                        core_reset <= 1'b0;
                        rom_ready  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ioctl_download) begin
                        state <= ST_LOAD;
                    end else begin
                        core_reset <= 1'b0;
                        rom_ready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
